// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter, fetch register and return-address stack
module pc_fetch #(
    parameter int PC_W      = 8,
    parameter int INSTR_W   = 8,
    parameter int RESET_PC  = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PC_W-1:0]    start_pc,
    input  logic               hlt,
    input  logic               stall,
    input  logic               jmp,
    input  logic               call,
    input  logic               ret,
    input  logic [PC_W-1:0]    jmp_addr,
    input  logic               br,
    input  logic [PC_W-1:0]    br_off,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    output logic               running,
    output logic               halted,
    output logic               ras_err
);

    localparam int RAS_AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RAS_DEPTH + 1);
    localparam logic [PC_W-1:0]   L_RESET_PC = PC_W'(RESET_PC);
    localparam logic [RAS_AW-1:0] L_RAS_LAST = RAS_AW'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0]  L_RAS_FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic [PC_W-1:0]    r_instr_pc;
    logic [PC_W-1:0]    w_instr_pc_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_ras_err;
    logic               w_err_set;

    logic [PC_W-1:0]    r_ras [RAS_DEPTH];
    logic [RAS_AW-1:0]  r_sp;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_push;
    logic               w_pop;
    logic [RAS_AW-1:0]  w_top_idx;
    logic [RAS_AW-1:0]  w_sp_inc;
    logic               w_ras_full;
    logic               w_ras_empty;
    logic [PC_W-1:0]    w_pc_inc;

    assign w_pc_inc    = r_pc + PC_W'(1);
    // r_sp is the next push slot; the newest entry sits just below it, circularly
    assign w_top_idx   = (r_sp == '0) ? L_RAS_LAST : r_sp - RAS_AW'(1);
    assign w_sp_inc    = (r_sp == L_RAS_LAST) ? '0 : r_sp + RAS_AW'(1);
    assign w_ras_full  = (r_cnt == L_RAS_FULL);
    assign w_ras_empty = (r_cnt == '0);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = 1'b0;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_err_set      = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = start_pc;
                end
            end
            ST_RUN: begin
                if (hlt) begin
                    w_state_nxt = ST_HALT;
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (ret) begin
                    if (w_ras_empty) begin
                        w_pc_nxt  = w_pc_inc;
                        w_err_set = 1'b1;
                    end else begin
                        w_pc_nxt = r_ras[w_top_idx];
                        w_pop    = 1'b1;
                    end
                end else if (call) begin
                    w_push    = 1'b1;
                    w_err_set = w_ras_full;
                    w_pc_nxt  = jmp_addr;
                end else if (jmp) begin
                    w_pc_nxt = jmp_addr;
                end else if (br) begin
                    w_pc_nxt = r_pc + br_off;
                end else begin
                    w_instr_nxt    = imem_data;
                    w_instr_pc_nxt = r_pc;
                    w_valid_nxt    = 1'b1;
                    w_pc_nxt       = w_pc_inc;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= L_RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_ras_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_ras_err  <= r_ras_err | w_err_set;
        end
    end

    // When full, a push overwrites the oldest entry and the count saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else if (w_push) begin
            r_ras[r_sp] <= w_pc_inc;
            r_sp        <= w_sp_inc;
            if (!w_ras_full) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (w_pop) begin
            r_sp  <= w_top_idx;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign running     = (r_state == ST_RUN);
    assign halted      = (r_state == ST_HALT);
    assign ras_err     = r_ras_err;

endmodule
